// File: rtl/seg7_scan_reader_if.sv
// Multiplexed 7-segment display bus plus the recovered-frame outputs of the scan reader.
interface seg7_scan_reader_if #(
  parameter int NDIG = 4
);
  logic [6:0]        display;
  logic              ponto;
  logic [NDIG-1:0]   dig_sel;
  logic [4*NDIG-1:0] bcd_out;
  logic [NDIG-1:0]   dots_out;
  logic              valid;
  logic              err;
  logic              stale;

  modport master (
    output display, ponto, dig_sel,
    input  bcd_out, dots_out, valid, err, stale
  );

  modport slave (
    input  display, ponto, dig_sel,
    output bcd_out, dots_out, valid, err, stale
  );
endinterface

// File: rtl/seg7_scan_reader.sv
// Watches a multiplexed 7-segment bus, debounces each digit slot, decodes it back to BCD
// and publishes a complete frame with a one-cycle valid pulse.
module seg7_scan_reader #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_reader_if.slave     bus
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    BLANK,
    SETTLE,
    CAPTURED
  } state_e;

  // Returns {invalid, digit}; unknown patterns read as F.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1111110: decode = 5'h00;
      7'b0110000: decode = 5'h01;
      7'b1101101: decode = 5'h02;
      7'b1111001: decode = 5'h03;
      7'b0110011: decode = 5'h04;
      7'b1011011: decode = 5'h05;
      7'b1011111: decode = 5'h06;
      7'b1110000: decode = 5'h07;
      7'b1111111: decode = 5'h08;
      7'b1111011: decode = 5'h09;
      default:    decode = 5'h1F;
    endcase
  endfunction

  logic [6:0]        disp_q, disp_d;
  logic              ponto_q, ponto_d;
  logic [NDIG-1:0]   sel_q, sel_d;
  logic [6:0]        prev_disp_q, prev_disp_d;
  logic              prev_ponto_q, prev_ponto_d;
  logic [NDIG-1:0]   prev_sel_q, prev_sel_d;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [NDIG-1:0]   mask_q, mask_d;
  logic [4*NDIG-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NDIG-1:0]   shadow_dot_q, shadow_dot_d;
  logic [NDIG-1:0]   shadow_inv_q, shadow_inv_d;

  logic [4*NDIG-1:0] bcd_q, bcd_d;
  logic [NDIG-1:0]   dots_q, dots_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              stale_q, stale_d;

  logic              one_hot;
  logic              same;
  logic              capture;
  logic [4:0]        dec;

  assign one_hot = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
  assign same    = ({sel_q, disp_q, ponto_q} == {prev_sel_q, prev_disp_q, prev_ponto_q});
  assign dec     = decode(disp_q);

  always_comb begin
    disp_d       = bus.display;
    ponto_d      = bus.ponto;
    sel_d        = bus.dig_sel;
    prev_disp_d  = disp_q;
    prev_ponto_d = ponto_q;
    prev_sel_d   = sel_q;
  end

  // The sample that first arrives counts as the first stable sample of its run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      BLANK: begin
        cnt_d = '0;
        if (one_hot) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end
      end
      SETTLE: begin
        if (!one_hot) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else if (!same) begin
          cnt_d = CW'(1);
        end else if (cnt_q == CW'(STABLE_CYC - 1)) begin
          capture = 1'b1;
          state_d = CAPTURED;
          cnt_d   = CW'(STABLE_CYC);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURED: begin
        if (!one_hot) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else if (!same) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Completion acts on last cycle's full mask, so a capture landing in the same
  // cycle is applied after the clear and starts the next frame.
  always_comb begin
    mask_d       = mask_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dot_d = shadow_dot_q;
    shadow_inv_d = shadow_inv_q;
    bcd_d        = bcd_q;
    dots_d       = dots_q;
    valid_d      = 1'b0;
    err_d        = err_q;
    stale_d      = stale_q;
    to_cnt_d     = to_cnt_q;

    if (mask_q == '1) begin
      bcd_d   = shadow_bcd_q;
      dots_d  = shadow_dot_q;
      err_d   = |shadow_inv_q;
      valid_d = 1'b1;
      stale_d = 1'b0;
      mask_d  = '0;
    end

    if (capture) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
      to_cnt_d = '0;
      mask_d   = '0;
      stale_d  = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    for (int unsigned i = 0; i < NDIG; i++) begin
      if (capture && sel_q[i]) begin
        shadow_bcd_d[4*i +: 4] = dec[3:0];
        shadow_dot_d[i]        = ponto_q;
        shadow_inv_d[i]        = dec[4];
        mask_d[i]              = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q       <= '0;
      ponto_q      <= 1'b0;
      sel_q        <= '0;
      prev_disp_q  <= '0;
      prev_ponto_q <= 1'b0;
      prev_sel_q   <= '0;
      state_q      <= BLANK;
      cnt_q        <= '0;
      to_cnt_q     <= '0;
      mask_q       <= '0;
      shadow_bcd_q <= '0;
      shadow_dot_q <= '0;
      shadow_inv_q <= '0;
      bcd_q        <= '0;
      dots_q       <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      disp_q       <= disp_d;
      ponto_q      <= ponto_d;
      sel_q        <= sel_d;
      prev_disp_q  <= prev_disp_d;
      prev_ponto_q <= prev_ponto_d;
      prev_sel_q   <= prev_sel_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      to_cnt_q     <= to_cnt_d;
      mask_q       <= mask_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dot_q <= shadow_dot_d;
      shadow_inv_q <= shadow_inv_d;
      bcd_q        <= bcd_d;
      dots_q       <= dots_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      stale_q      <= stale_d;
    end
  end

  assign bus.bcd_out  = bcd_q;
  assign bus.dots_out = dots_q;
  assign bus.valid    = valid_q;
  assign bus.err      = err_q;
  assign bus.stale    = stale_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed scans plus random traffic against a run-length
// reference model, with literal expectations on the headline scenarios.
module tb_seg7_scan_reader;

  localparam int NDIG       = 4;
  localparam int STABLE_CYC = 4;
  localparam int TIMEOUT    = 4096;

  localparam logic [6:0] SEG [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   vcount = 0;

  seg7_scan_reader_if #(.NDIG(NDIG)) bus ();

  seg7_scan_reader #(
    .NDIG(NDIG),
    .STABLE_CYC(STABLE_CYC),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern -> {invalid, digit} by table search.
  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    ref_decode = 5'h1F;
    for (int i = 0; i < 10; i++)
      if (SEG[i] == p) ref_decode = {1'b0, 4'(i)};
  endfunction

  // Reference model: a digit is accepted when its one-hot sample has been seen
  // exactly STABLE_CYC times in a row; frame publishes one edge after the mask fills.
  logic [11:0] m_smp = '0, m_last = '0;
  int          m_run = 0, m_since = 0;
  logic [3:0]  m_mask = '0, m_sh_dot = '0, m_sh_inv = '0;
  logic [15:0] m_sh_bcd = '0;
  logic [15:0] exp_bcd = '0;
  logic [3:0]  exp_dots = '0;
  logic        exp_valid = 1'b0, exp_err = 1'b0, exp_stale = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [11:0] s;
    logic [4:0]  d;
    if (!rst_n) begin
      m_smp = '0; m_last = '0; m_run = 0; m_since = 0;
      m_mask = '0; m_sh_dot = '0; m_sh_inv = '0; m_sh_bcd = '0;
      exp_bcd = '0; exp_dots = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_stale = 1'b0;
    end else begin
      s     = m_smp;
      m_smp = {bus.dig_sel, bus.display, bus.ponto};
      if ($countones(s[11:8]) == 1) m_run = (s == m_last) ? m_run + 1 : 1;
      else                          m_run = 0;
      m_last    = s;
      exp_valid = 1'b0;
      if (m_mask == 4'hF) begin
        exp_bcd   = m_sh_bcd;
        exp_dots  = m_sh_dot;
        exp_err   = |m_sh_inv;
        exp_valid = 1'b1;
        exp_stale = 1'b0;
        m_mask    = '0;
      end
      if (m_run == STABLE_CYC) begin
        d = ref_decode(s[7:1]);
        for (int i = 0; i < NDIG; i++) begin
          if (s[8+i]) begin
            m_sh_bcd[4*i +: 4] = d[3:0];
            m_sh_dot[i]        = s[0];
            m_sh_inv[i]        = d[4];
            m_mask[i]          = 1'b1;
          end
        end
        m_since = 0;
      end else begin
        m_since++;
        if (m_since == TIMEOUT) begin
          m_since   = 0;
          m_mask    = '0;
          exp_stale = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("valid",    32'(bus.valid),    32'(exp_valid));
    check("bcd_out",  32'(bus.bcd_out),  32'(exp_bcd));
    check("dots_out", 32'(bus.dots_out), 32'(exp_dots));
    check("err",      32'(bus.err),      32'(exp_err));
    check("stale",    32'(bus.stale),    32'(exp_stale));
  end

  always @(posedge clk) begin
    #1;
    if (bus.valid === 1'b1) vcount++;
  end

  task automatic drive(input int slot, input logic [6:0] pat, input logic dot, input int n);
    bus.dig_sel = 4'(1 << slot);
    bus.display = pat;
    bus.ponto   = dot;
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    bus.dig_sel = '0;
    bus.display = '0;
    bus.ponto   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [27:0] pats, input logic [3:0] dots);
    for (int s = 3; s >= 0; s--) begin
      drive(s, pats[7*s +: 7], dots[s], 8);
      blank(2);
    end
  endtask

  function automatic logic [27:0] pat4(input int d3, input int d2, input int d1, input int d0);
    pat4 = {SEG[d3], SEG[d2], SEG[d1], SEG[d0]};
  endfunction

  initial begin
    int v0, k;
    logic [6:0] p;
    bus.dig_sel = '0;
    bus.display = '0;
    bus.ponto   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_bcd",   32'(bus.bcd_out), 32'h0);
    check("reset_valid", 32'(bus.valid),   32'h0);
    rst_n = 1'b1;
    blank(2);

    v0 = vcount;
    scan(pat4(0, 4, 2, 7), 4'b0000);
    check("t1_pulses", 32'(vcount - v0),   32'd1);
    check("t1_bcd",    32'(bus.bcd_out),   32'h0427);
    check("t1_dots",   32'(bus.dots_out),  32'h0);
    check("t1_err",    32'(bus.err),       32'h0);

    scan(pat4(0, 4, 2, 7), 4'b0010);
    check("t2_bcd",  32'(bus.bcd_out),  32'h0427);
    check("t2_dots", 32'(bus.dots_out), 32'h2);

    // Final digit from blank: valid expected STABLE_CYC+2 cycles after it appears.
    drive(3, SEG[9], 1'b0, 8); blank(2);
    drive(2, SEG[8], 1'b0, 8); blank(2);
    drive(1, SEG[5], 1'b0, 8); blank(2);
    bus.dig_sel = 4'b0001; bus.display = SEG[1]; bus.ponto = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin k = i; break; end
    end
    check("latency", 32'(k), 32'(STABLE_CYC + 2));
    check("lat_bcd", 32'(bus.bcd_out), 32'h9851);
    drive(0, SEG[1], 1'b0, 4); blank(2);

    v0 = vcount;
    drive(3, SEG[0], 1'b0, 8); blank(2);
    drive(1, SEG[2], 1'b0, 8); blank(2);
    drive(0, SEG[7], 1'b0, 8); blank(2);
    for (int i = 0; i < 10; i++) drive(2, (i % 2 == 0) ? SEG[2] : SEG[3], 1'b0, 3);
    check("toggle_no_valid", 32'(vcount - v0), 32'd0);
    drive(2, SEG[3], 1'b0, 8); blank(2);
    check("toggle_pulses", 32'(vcount - v0), 32'd1);
    check("toggle_bcd",    32'(bus.bcd_out), 32'h0327);

    scan({SEG[0], SEG[4], SEG[2], 7'b0000001}, 4'b0000);
    check("inv_bcd", 32'(bus.bcd_out), 32'h042F);
    check("inv_err", 32'(bus.err),     32'h1);
    scan(pat4(0, 4, 2, 7), 4'b0000);
    check("clean_err", 32'(bus.err), 32'h0);

    v0 = vcount;
    drive(0, SEG[5], 1'b0, 8); blank(2);
    drive(1, SEG[6], 1'b0, 8);
    blank(TIMEOUT + 10);
    check("to_stale",    32'(bus.stale),     32'h1);
    check("to_no_valid", 32'(vcount - v0),   32'd0);
    check("to_bcd_hold", 32'(bus.bcd_out),   32'h0427);
    scan(pat4(1, 2, 3, 4), 4'b1000);
    check("to_recover_valid", 32'(vcount - v0), 32'd1);
    check("to_recover_stale", 32'(bus.stale),   32'h0);
    check("to_recover_bcd",   32'(bus.bcd_out), 32'h1234);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) p = 7'($urandom);
      else                           p = SEG[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) begin
        bus.dig_sel = 4'b0011; bus.display = p; bus.ponto = 1'($urandom);
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end else begin
        k = $urandom_range(1, 9);
        drive($urandom_range(0, 3), p, 1'($urandom), k);
        if (k > 4 && $urandom_range(0, 2) == 0) begin
          bus.display = p ^ 7'(1 << $urandom_range(0, 6));
          @(negedge clk);
          bus.display = p;
          repeat ($urandom_range(1, 6)) @(negedge clk);
        end
      end
      blank($urandom_range(0, 3));
    end
    blank(4);

    scan(pat4(0, 4, 2, 7), 4'b0000);
    drive(3, SEG[1], 1'b0, 8); blank(2);
    drive(2, SEG[1], 1'b0, 8); blank(2);
    drive(1, SEG[1], 1'b0, 8); blank(1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_bcd",   32'(bus.bcd_out),  32'h0);
    check("rst_dots",  32'(bus.dots_out), 32'h0);
    check("rst_valid", 32'(bus.valid),    32'h0);
    check("rst_err",   32'(bus.err),      32'h0);
    check("rst_stale", 32'(bus.stale),    32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    v0 = vcount;
    drive(0, SEG[1], 1'b0, 8);
    blank(20);
    check("rst_no_valid", 32'(vcount - v0),  32'd0);
    check("rst_bcd_hold", 32'(bus.bcd_out),  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Receive-side counterpart of the team's BCD-to-7-segment encoder: observes a multiplexed 7-segment display bus (segments, dot, digit select) and recovers the displayed BCD digits and decimal points.
- Used in the temperature monitor for self-check/loopback: compares what the display shows against the internal reading, and feeds the debug/readback path.
- Filters scan glitches, decodes each digit pattern, assembles a full frame and reports it with a one-cycle valid pulse.

Parameters:
- NDIG, 4, number of multiplexed digits (slot 0 = dig_sel[0], least significant).
- STABLE_CYC, 4, consecutive identical samples required before a digit is accepted (>=2).
- TIMEOUT, 4096, cycles without any accepted digit before a partial frame is discarded.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- display  in  7  segment pattern, bit6=a … bit0=g, active high.
- ponto  in  1  decimal point, active high.
- dig_sel  in  NDIG  digit enable, one-hot active high; all-zero = blanking.
- bcd_out  out  4*NDIG  decoded digits; slot i at bits [4i+3:4i].
- dots_out  out  NDIG  decimal point per slot.
- valid  out  1  one-cycle pulse: new frame on bcd_out/dots_out.
- err  out  1  frame contained an undecodable pattern; updated with valid.
- stale  out  1  set on timeout, cleared on next valid.

Behaviour:
- Reset (async, rst_n=0): bcd_out=0, dots_out=0, valid=0, err=0, stale=0; shadow slots, capture mask, stability counter, timeout counter cleared; FSM to BLANK.
- Input stage: display, ponto, dig_sel registered once; all logic uses registered samples.
- Decode table (pattern -> digit): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9; any other pattern -> 4'hF and invalid.
- FSM states:
  - BLANK: registered dig_sel is zero or not one-hot; counter=0. Go SETTLE when one-hot seen.
  - SETTLE: counter increments each cycle the {dig_sel,display,ponto} sample equals the previous one; any change restarts the counter at 1 (a change to blank/non-one-hot goes to BLANK). When the counter reaches STABLE_CYC, write decoded digit, dot, and invalid flag into the selected shadow slot, set its mask bit, go to CAPTURED.
  - CAPTURED: hold, no recapture, until the sample changes; then go SETTLE (count=1) or BLANK.
- Re-capture of an already-masked slot before the frame completes overwrites it (latest wins).
- Frame completion: the cycle after mask becomes all-ones, copy shadow to bcd_out/dots_out, err = OR of slot invalid flags, valid=1 for exactly one cycle, stale=0, mask cleared. Outputs otherwise hold their last frame.
- Latency: final digit held stable on pins from cycle 0 -> valid high at cycle STABLE_CYC+2.
- Timeout: counter reset on every capture; on reaching TIMEOUT, mask cleared, stale=1, outputs unchanged, no valid pulse.
- Capture and frame completion in the same cycle cannot collide (completion is registered one cycle later); a capture in the completion cycle lands in the new, cleared mask.
- rst_n asserted mid-frame discards the partial frame immediately.

Test Plan:
- Scan slots 3..0 with patterns for 0,4,2,7, each held 8 cycles with 2 blank cycles between -> one valid pulse, bcd_out=16'h0427, dots_out=0, err=0.
- Same scan, slot 1 with ponto=1 -> bcd_out=16'h0427, dots_out=4'b0010.
- Slot 2 pattern toggles between 1101101 and 1111001 every 3 cycles for 30 cycles, then held 1111001 -> slot 2 reads 3; no valid until all slots captured; no intermediate capture.
- Slot 0 driven 0000001 (invalid) in an otherwise valid scan -> valid pulse, bcd_out[3:0]=4'hF, err=1; next clean frame -> err=0.
- Capture slots 0 and 1 only, then blank for TIMEOUT+10 cycles -> stale=1, no valid, bcd_out unchanged; full scan afterwards -> valid, stale=0.
- rst_n pulsed low after 3 slots captured -> all outputs 0 immediately; subsequent single-slot capture produces no valid.
